// File: rtl/ssd1306_procedure_scheduler_pkg.sv
// Shared types and constants for the SSD1306 procedure scheduler.
// Holds the FSM encoding, requester indices and the default microcode offsets.
package ssd1306_sched_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_START,
    S_RUN,
    S_ACK,
    S_FAULT
  } sched_state_t;

  localparam int REQ_INIT       = 0;
  localparam int REQ_DISPLAY_ON = 1;
  localparam int REQ_FRAME      = 2;
  localparam int REQ_POWER_OFF  = 3;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ADDR_BITS = 6;

  // Slice i is the microcode entry point of requester i.
  localparam logic [DEF_NUM_REQ*DEF_ADDR_BITS-1:0] DEF_PROC_OFFSETS =
    {6'd40, 6'd32, 6'd24, 6'd0};

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd1306_procedure_scheduler_if.sv
// Requester and executor handshake bundle of the procedure scheduler.
// master = scheduler side, slave = application FSMs plus microcode executor.
interface ssd1306_procedure_scheduler_if
  import ssd1306_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_BITS = DEF_ADDR_BITS
);

  logic [NUM_REQ-1:0]   req_in;
  logic [NUM_REQ-1:0]   ack_out;
  logic [ADDR_BITS-1:0] proc_offset_out;
  logic                 proc_start_out;
  logic                 proc_done_in;

  modport master (
    input  req_in,
    input  proc_done_in,
    output ack_out,
    output proc_offset_out,
    output proc_start_out
  );

  modport slave (
    output req_in,
    output proc_done_in,
    input  ack_out,
    input  proc_offset_out,
    input  proc_start_out
  );

endinterface

// File: rtl/ssd1306_procedure_scheduler_arbiter.sv
// Fixed-priority arbiter: lowest set request index wins, one-hot and encoded.
// Purely combinational, no state.
module ssd1306_fixed_prio_arbiter
  import ssd1306_sched_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int IDX_W = idx_bits(N)
) (
  input  logic [N-1:0]     req_vec,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_vld    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_vec[i] && !gnt_vld) begin
        gnt_onehot[i] = 1'b1;
        gnt_idx       = IDX_W'(i);
        gnt_vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd1306_procedure_scheduler.sv
// Shares the SSD1306 microcode executor between requesters; init runs first after reset.
// Request in idle -> start next cycle; start held until the executor leaves idle, ack one cycle after done.
// Optional watchdog with SSD1306_SCHED_WATCHDOG_EN: stuck start/run -> sticky fault.
module ssd1306_procedure_scheduler
  import ssd1306_sched_pkg::*;
#(
  parameter int NUM_REQ         = DEF_NUM_REQ,
  parameter int ADDR_BITS       = DEF_ADDR_BITS,
  parameter     PROC_OFFSETS    = DEF_PROC_OFFSETS,
  parameter int WATCHDOG_CYCLES = 200000
) (
  input  logic                          clk_in,
  input  logic                          reset_n_in,
  ssd1306_procedure_scheduler_if.master bus,
  output logic                          busy_out,
  output logic                          init_done_out,
  output logic                          fault_out
);

  localparam int IDX_W = idx_bits(NUM_REQ);

  if ($bits(PROC_OFFSETS) != NUM_REQ * ADDR_BITS) begin : g_bad_offsets
    $error("PROC_OFFSETS must be exactly NUM_REQ*ADDR_BITS bits wide");
  end
  if (WATCHDOG_CYCLES < 1) begin : g_bad_watchdog
    $error("WATCHDOG_CYCLES must be at least 1");
  end

  logic [ADDR_BITS-1:0] offs [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_offs
    assign offs[g] = PROC_OFFSETS[g*ADDR_BITS +: ADDR_BITS];
  end

  sched_state_t         state, state_nxt;
  logic [IDX_W-1:0]     grant, grant_nxt;
  logic [ADDR_BITS-1:0] offset_q, offset_nxt;
  logic [NUM_REQ-1:0]   pending, pending_nxt;
  logic                 again, again_nxt;
  logic                 init_done, init_done_nxt;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   req_cand;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;
  logic [ADDR_BITS-1:0] win_off;

  // A pulse on req_in is eligible in the same cycle it arrives.
  assign req_cand = pending | bus.req_in;

  ssd1306_fixed_prio_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_vec    (req_cand),
    .gnt_onehot (win_onehot),
    .gnt_idx    (win_idx),
    .gnt_vld    (win_any)
  );

  always_comb begin
    win_off = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) win_off = win_off | offs[i];
    end
  end

`ifdef SSD1306_SCHED_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(WATCHDOG_CYCLES - 1);
  logic [31:0] wd_cnt;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wd_cnt <= '0;
    end else if (state_nxt == S_START && state != S_START) begin
      wd_cnt <= '0;
    end else if (state == S_START || state == S_RUN) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    offset_nxt    = offset_q;
    pending_nxt   = pending | bus.req_in;
    again_nxt     = again;
    init_done_nxt = init_done;

    case (state)
      S_BOOT: begin
        grant_nxt  = IDX_W'(REQ_INIT);
        offset_nxt = offs[REQ_INIT];
        again_nxt  = 1'b0;
        state_nxt  = S_START;
      end
      S_IDLE: begin
        if (init_done && win_any) begin
          grant_nxt  = win_idx;
          offset_nxt = win_off;
          again_nxt  = 1'b0;
          state_nxt  = S_START;
        end
      end
      S_START: begin
        if (bus.req_in[grant]) again_nxt = 1'b1;
        if (!bus.proc_done_in) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.req_in[grant]) again_nxt = 1'b1;
        if (bus.proc_done_in) state_nxt = S_ACK;
      end
      S_ACK: begin
        // A re-request seen while this index was in service keeps it pending.
        if (!(bus.req_in[grant] || again)) pending_nxt[grant] = 1'b0;
        again_nxt = 1'b0;
        if (grant == IDX_W'(REQ_INIT)) init_done_nxt = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase

`ifdef SSD1306_SCHED_WATCHDOG_EN
    if ((state == S_START || state == S_RUN) && wd_cnt >= WD_LIMIT) begin
      state_nxt = S_FAULT;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= S_BOOT;
      grant     <= '0;
      offset_q  <= '0;
      pending   <= '0;
      again     <= 1'b0;
      init_done <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      offset_q  <= offset_nxt;
      pending   <= pending_nxt;
      again     <= again_nxt;
      init_done <= init_done_nxt;
      busy_q    <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    bus.ack_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.ack_out[i] = (state == S_ACK) && (grant == IDX_W'(i));
    end
  end

  assign bus.proc_start_out  = (state == S_START);
  assign bus.proc_offset_out = offset_q;
  assign busy_out            = busy_q;
  assign init_done_out       = init_done;

`ifdef SSD1306_SCHED_WATCHDOG_EN
  assign fault_out = (state == S_FAULT);
`else
  assign fault_out = 1'b0;
`endif

endmodule

// File: tb/tb_ssd1306_procedure_scheduler.sv
// Directed bench for the procedure scheduler with a simple executor model.
// Executor: done drops 3 cycles after start is seen, rises 20 cycles later.
module tb_ssd1306_procedure_scheduler;

  logic clk_in = 1'b0;
  logic reset_n_in;
  logic busy_out, init_done_out, fault_out;
  logic ex_stuck;

  int n_cmp = 0;
  int n_bad = 0;
  int ex_phase = 0;
  int ex_cnt = 0;

  always #5 clk_in = ~clk_in;

  ssd1306_procedure_scheduler_if #(.NUM_REQ(4), .ADDR_BITS(6)) bus ();

  ssd1306_procedure_scheduler #(
    .NUM_REQ         (4),
    .ADDR_BITS       (6),
    .WATCHDOG_CYCLES (100)
  ) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .bus           (bus),
    .busy_out      (busy_out),
    .init_done_out (init_done_out),
    .fault_out     (fault_out)
  );

  // Executor model, driven away from the scheduler's active edge.
  always @(negedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ex_phase = 0;
      ex_cnt = 0;
      bus.proc_done_in = 1'b1;
    end else if (ex_stuck) begin
      ex_phase = 0;
      bus.proc_done_in = 1'b1;
    end else begin
      case (ex_phase)
        0: if (bus.proc_start_out) begin ex_phase = 1; ex_cnt = 1; end
        1: if (ex_cnt == 3) begin bus.proc_done_in = 1'b0; ex_phase = 2; ex_cnt = 1; end
           else ex_cnt++;
        2: if (ex_cnt == 20) begin bus.proc_done_in = 1'b1; ex_phase = 0; end
           else ex_cnt++;
        default: ex_phase = 0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag, input logic [5:0] off);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.proc_start_out) seen = 1;
    end
    check({tag, "_start"}, 32'(seen), 32'd1);
    check({tag, "_off"}, 32'(bus.proc_offset_out), 32'(off));
  endtask

  task automatic wait_ack(input string tag, input logic [3:0] ack);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.ack_out != 4'b0) seen = 1;
    end
    check({tag, "_ack"}, 32'(bus.ack_out), 32'(ack));
  endtask

  task automatic pulse_req(input logic [3:0] r);
    bus.req_in = r;
    @(negedge clk_in);
    bus.req_in = 4'b0;
  endtask

  initial begin
    reset_n_in = 1'b0;
    ex_stuck = 1'b0;
    bus.req_in = 4'b0;
    repeat (3) @(negedge clk_in);

    // reset state
    check("rst_start", 32'(bus.proc_start_out), 32'd0);
    check("rst_ack", 32'(bus.ack_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_init_done", 32'(init_done_out), 32'd0);
    check("rst_fault", 32'(fault_out), 32'd0);
    check("rst_off", 32'(bus.proc_offset_out), 32'd0);

    // 1: init issued automatically in the 2nd cycle
    reset_n_in = 1'b1;
    @(negedge clk_in);
    check("boot_start", 32'(bus.proc_start_out), 32'd1);
    check("boot_off", 32'(bus.proc_offset_out), 32'd0);
    check("boot_busy", 32'(busy_out), 32'd1);

    // 2: requests during init are latched
    repeat (5) @(negedge clk_in);
    pulse_req(4'b1010);
    wait_ack("init", 4'b0001);
    check("init_done_pre", 32'(init_done_out), 32'd0);
    @(negedge clk_in);
    check("init_done_post", 32'(init_done_out), 32'd1);
    check("gap_start", 32'(bus.proc_start_out), 32'd0);
    wait_start("t2_r1", 6'd24);
    wait_ack("t2_r1", 4'b0010);
    @(negedge clk_in);
    check("t2_gap_start", 32'(bus.proc_start_out), 32'd0);
    wait_start("t2_r3", 6'd40);
    wait_ack("t2_r3", 4'b1000);

    // 3: simultaneous requests, lowest index first, start one cycle after request
    repeat (4) @(negedge clk_in);
    check("t3_idle_busy", 32'(busy_out), 32'd0);
    pulse_req(4'b0110);
    check("t3_start_next", 32'(bus.proc_start_out), 32'd1);
    check("t3_off_first", 32'(bus.proc_offset_out), 32'd24);
    wait_ack("t3_r1", 4'b0010);
    wait_start("t3_r2", 6'd32);
    wait_ack("t3_r2", 4'b0100);

    // 4: re-request of the index in service is served again
    repeat (3) @(negedge clk_in);
    pulse_req(4'b0100);
    check("t4_start", 32'(bus.proc_start_out), 32'd1);
    repeat (8) @(negedge clk_in);
    check("t4_in_run", 32'(bus.proc_start_out), 32'd0);
    pulse_req(4'b0100);
    wait_ack("t4_first", 4'b0100);
    wait_start("t4_again", 6'd32);
    wait_ack("t4_second", 4'b0100);
    repeat (10) @(negedge clk_in);
    check("t4_no_third", 32'(busy_out), 32'd0);
    check("t4_init_kept", 32'(init_done_out), 32'd1);

    // 5: reset mid-run clears outputs at once, init reissued afterwards
    pulse_req(4'b1000);
    check("t5_start", 32'(bus.proc_start_out), 32'd1);
    check("t5_off", 32'(bus.proc_offset_out), 32'd40);
    repeat (8) @(negedge clk_in);
    #2 reset_n_in = 1'b0;
    #1;
    check("t5_async_start", 32'(bus.proc_start_out), 32'd0);
    check("t5_async_busy", 32'(busy_out), 32'd0);
    check("t5_async_init", 32'(init_done_out), 32'd0);
    check("t5_async_off", 32'(bus.proc_offset_out), 32'd0);
    repeat (2) @(negedge clk_in);
    reset_n_in = 1'b1;
    @(negedge clk_in);
    check("t5_reinit_start", 32'(bus.proc_start_out), 32'd1);
    check("t5_reinit_off", 32'(bus.proc_offset_out), 32'd0);
    wait_ack("t5_reinit", 4'b0001);
    @(negedge clk_in);
    check("t5_init_done", 32'(init_done_out), 32'd1);

    // 6: executor never leaves idle
    ex_stuck = 1'b1;
    repeat (2) @(negedge clk_in);
    pulse_req(4'b0100);
    check("t6_start", 32'(bus.proc_start_out), 32'd1);
`ifdef SSD1306_SCHED_WATCHDOG_EN
    repeat (99) @(negedge clk_in);
    check("t6_wd_before_start", 32'(bus.proc_start_out), 32'd1);
    check("t6_wd_before_fault", 32'(fault_out), 32'd0);
    @(negedge clk_in);
    check("t6_wd_fault", 32'(fault_out), 32'd1);
    check("t6_wd_start_off", 32'(bus.proc_start_out), 32'd0);
    repeat (20) @(negedge clk_in);
    check("t6_wd_sticky", 32'(fault_out), 32'd1);
`else
    repeat (300) @(negedge clk_in);
    check("t6_held_start", 32'(bus.proc_start_out), 32'd1);
    check("t6_no_fault", 32'(fault_out), 32'd0);
    check("t6_busy", 32'(busy_out), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
